// File: rtl/sa_pkg.sv
// Shared constants and types for the systolic-array output path: 8x8 matrix,
// 6-bit {row,col} entry addresses and the output buffer fill/drain state.
package sa_pkg;

   localparam int N       = 8;
   localparam int ADDR_BW = 6;
   localparam int ROW_BW  = 3;
   localparam int COL_BW  = ADDR_BW - ROW_BW;
   localparam int ENTRIES = N * N;

   localparam logic [ROW_BW-1:0] LAST_ROW = ROW_BW'(N - 1);

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Entry address layout: [5:3] = row, [2:0] = col.
   function automatic logic [ADDR_BW-1:0] entry_addr(input logic [ROW_BW-1:0] row,
                                                     input logic [COL_BW-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/output_buffer_regfile.sv
// 64-entry result store: 8 lane write ports (highest lane wins on an address
// collision), one combinational 8-word row read, and the per-cycle write mask.
module output_buffer_regfile
   import sa_pkg::*;
#(
   parameter int DATA_BW = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N-1:0]         we,
   input  logic [N*ADDR_BW-1:0] waddr,
   input  logic [N*DATA_BW-1:0] wdata,
   input  logic [ROW_BW-1:0]    rrow,
   output logic [N*DATA_BW-1:0] rdata,
   output logic [ENTRIES-1:0]   wmask
);

   logic [DATA_BW-1:0] mem_q [ENTRIES];

   // Lanes are visited in ascending order, so the last assignment (highest lane) wins.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int e = 0; e < ENTRIES; e++) begin
            mem_q[e] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (we[i]) begin
               mem_q[waddr[ADDR_BW*i +: ADDR_BW]] <= wdata[DATA_BW*i +: DATA_BW];
            end
         end
      end
   end

   always_comb begin
      wmask = '0;
      for (int i = 0; i < N; i++) begin
         if (we[i]) begin
            wmask[waddr[ADDR_BW*i +: ADDR_BW]] = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_rd_col
         assign rdata[DATA_BW*gi +: DATA_BW] = mem_q[entry_addr(rrow, COL_BW'(gi))];
      end
   endgenerate

endmodule

// File: rtl/output_buffer_drain.sv
// Output buffer drain: collects 64 skewed lane writes, then streams the matrix
// out in raster order, one 8-word row per valid/ready beat.
module output_buffer_drain
   import sa_pkg::*;
#(
   parameter int DATA_BW = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   input  logic [N-1:0]         wr_en,
   input  logic [N*ADDR_BW-1:0] wr_addr,
   input  logic [N*DATA_BW-1:0] wr_data,
   output logic                 wr_ready,
   output logic                 wr_drop,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [N*DATA_BW-1:0] rd_data,
   output logic [ROW_BW-1:0]    rd_row,
   output logic                 rd_last
);

   state_t              state_q, state_d;
   logic [ENTRIES-1:0]  bitmap_q, bitmap_d;
   logic [ROW_BW-1:0]   row_ptr_q, row_ptr_d;
   logic                drop_q, drop_d;
   logic [N-1:0]        wr_acc;
   logic [ENTRIES-1:0]  wr_mask;

   // Flush discards same-cycle writes outright, so they never reach storage.
   assign wr_acc = (state_q == FILL && !flush) ? wr_en : '0;

   output_buffer_regfile #(
      .DATA_BW (DATA_BW)
   ) u_regfile (
      .clk   (clk),
      .rstn  (rstn),
      .we    (wr_acc),
      .waddr (wr_addr),
      .wdata (wr_data),
      .rrow  (row_ptr_q),
      .rdata (rd_data),
      .wmask (wr_mask)
   );

   always_comb begin
      state_d   = state_q;
      bitmap_d  = bitmap_q;
      row_ptr_d = row_ptr_q;
      drop_d    = (state_q == DRAIN) && (|wr_en) && !flush;
      if (flush) begin
         state_d   = FILL;
         bitmap_d  = '0;
         row_ptr_d = '0;
      end else begin
         case (state_q)
            FILL: begin
               bitmap_d = bitmap_q | wr_mask;
               if (&bitmap_d) begin
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (rd_ready) begin
                  if (row_ptr_q == LAST_ROW) begin
                     state_d   = FILL;
                     bitmap_d  = '0;
                     row_ptr_d = '0;
                  end else begin
                     row_ptr_d = row_ptr_q + ROW_BW'(1);
                  end
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= FILL;
         bitmap_q  <= '0;
         row_ptr_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitmap_q  <= bitmap_d;
         row_ptr_q <= row_ptr_d;
         drop_q    <= drop_d;
      end
   end

   assign wr_ready = (state_q == FILL);
   assign rd_valid = (state_q == DRAIN);
   assign rd_row   = row_ptr_q;
   assign rd_last  = rd_valid && (row_ptr_q == LAST_ROW);
   assign wr_drop  = drop_q;

endmodule
